ara_eoc_monitor: RTL

ARA_EOC_MONITOR -- requirements
Module: ara_eoc_monitor

---
 rtl/ara_eoc_pkg.sv | 17 +
 rtl/ara_eoc_cycle_counter.sv | 29 ++
 rtl/ara_eoc_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/ara_eoc_pkg.sv
// ara_eoc_pkg
//   Shared definitions for the end-of-computation monitor: FSM state
//   encoding, default snoop addresses and the exit-valid bit index.
package ara_eoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2,
        ST_EXITED  = 2'd3
    } eoc_state_e;

    localparam logic [63:0] TOHOST_ADDR_DEFAULT = 64'h8000_1000;
    localparam logic [63:0] CTRL_ADDR_DEFAULT   = 64'h8000_1008;
    localparam int unsigned EXIT_VALID_BIT      = 0;

endpackage

// File: rtl/ara_eoc_cycle_counter.sv
// ara_eoc_cycle_counter
//   64-bit saturating cycle counter.
//   Ports:
//     clk_i     clock
//     rst_ni    asynchronous active-low reset (count -> 0)
//     clear_i   synchronous clear, highest priority
//     enable_i  count one per cycle while high
//     freeze_i  hold the current value this cycle even if enabled
//     count_o   current count, sticks at all-ones
module ara_eoc_cycle_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        freeze_i,
    output logic [63:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (enable_i && !freeze_i && (count_o != '1)) begin
            count_o <= count_o + 64'd1;
        end
    end

endmodule

// File: rtl/ara_eoc_monitor.sv
// ara_eoc_monitor
//   Passive snooper of a write channel. Captures the tohost exit code and,
//   when built with ARA_EOC_RUNTIME_EN, measures the cycle count between
//   start/stop writes to the control address.
//   Ports:
//     clk_i, rst_ni       clock, asynchronous active-low reset
//     wr_valid_i/ready_i  snooped handshake (write fires when both high)
//     wr_addr_i           snooped write address
//     wr_data_i           snooped write data (bits [63:0] used)
//     exit_o              {code, exit_valid}, sticky until reset
//     runtime_o           live counter value
//     runtime_valid_o     runtime_o holds a completed measurement
//   Build option: ARA_EOC_RUNTIME_EN enables the runtime counter; without it
//   runtime outputs are tied to 0 and control writes are ignored.
//
//   state      | meaning
//   ST_IDLE    | waiting for start or exit
//   ST_RUNNING | counter incrementing each cycle
//   ST_DONE    | measurement complete, runtime_valid_o high
//   ST_EXITED  | exit code captured, all further writes ignored
module ara_eoc_monitor
    import ara_eoc_pkg::*;
#(
    parameter int unsigned            AddrWidth  = 64,
    parameter int unsigned            DataWidth  = 64,
    parameter logic [AddrWidth-1:0]   TohostAddr = AddrWidth'(TOHOST_ADDR_DEFAULT),
    parameter logic [AddrWidth-1:0]   CtrlAddr   = AddrWidth'(CTRL_ADDR_DEFAULT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_valid_i,
    input  logic                  wr_ready_i,
    input  logic [AddrWidth-1:0]  wr_addr_i,
    input  logic [DataWidth-1:0]  wr_data_i,
    output logic [63:0]           exit_o,
    output logic [63:0]           runtime_o,
    output logic                  runtime_valid_o
);

    eoc_state_e  state_q;
    logic        fire;
    logic [63:0] data64;
    logic        tohost_hit;
    logic        exit_req;

    assign fire       = wr_valid_i & wr_ready_i;
    assign data64     = wr_data_i[63:0];
    assign tohost_hit = fire && (wr_addr_i == TohostAddr);
    assign exit_req   = tohost_hit && data64[EXIT_VALID_BIT];

`ifdef ARA_EOC_RUNTIME_EN
    logic ctrl_hit;
    logic start_req;
    logic stop_req;
    logic rt_valid_q;
    logic cnt_clear;

    // Tohost wins if both parameters are ever set to the same address.
    assign ctrl_hit  = fire && (wr_addr_i == CtrlAddr) && !tohost_hit;
    assign start_req = ctrl_hit &&  data64[0];
    assign stop_req  = ctrl_hit && !data64[0];
    assign cnt_clear = start_req && (state_q != ST_EXITED);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            exit_o     <= '0;
            rt_valid_q <= 1'b0;
        end else if (state_q != ST_EXITED) begin
            if (exit_req) begin
                exit_o  <= data64;
                state_q <= ST_EXITED;
                if (state_q == ST_RUNNING) begin
                    rt_valid_q <= 1'b1;
                end
            end else if (start_req) begin
                state_q    <= ST_RUNNING;
                rt_valid_q <= 1'b0;
            end else if (stop_req && (state_q == ST_RUNNING)) begin
                state_q    <= ST_DONE;
                rt_valid_q <= 1'b1;
            end
        end
    end

    // The stop cycle is still RUNNING, so its final increment happens
    // naturally; an exit freezes the count instead.
    ara_eoc_cycle_counter u_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cnt_clear),
        .enable_i (state_q == ST_RUNNING),
        .freeze_i (exit_req),
        .count_o  (runtime_o)
    );

    assign runtime_valid_o = rt_valid_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            exit_o  <= '0;
        end else if ((state_q != ST_EXITED) && exit_req) begin
            exit_o  <= data64;
            state_q <= ST_EXITED;
        end
    end

    assign runtime_o       = '0;
    assign runtime_valid_o = 1'b0;
`endif

endmodule
